// File: rtl/ram_dev.sv
// rtl/ram_dev.sv - behavioural bus RAM device with four-phase handshake and programmable wait states
module ram_dev #(
    parameter int word_width  = 32,
    parameter int addr_width  = 10,
    parameter int wait_cycles = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] ram_ctrl,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] ram_stat,
    output logic [word_width-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [15:0] wait_load = 16'(wait_cycles);

    state_t                  state;
    state_t                  state_next;
    logic [15:0]             cnt;
    logic [1:0]              op_q;
    logic [word_width-1:0]   addr_q;
    logic [word_width-1:0]   data_q;
    logic                    err_q;
    logic                    req;
    logic                    in_range;
    logic                    enter_ack;
    logic [addr_width-1:0]   idx;
    logic                    unused_ctrl;

    logic [word_width-1:0]   mem [2**addr_width];

    assign req         = |ram_ctrl[1:0];
    assign unused_ctrl = ^ram_ctrl[word_width-1:2];
    // Every latched address bit takes part, so any upper bit set is out of range.
    assign in_range    = (addr_q >> addr_width) == '0;
    assign idx         = addr_q[addr_width-1:0];
    assign enter_ack   = (state == WAIT) && (cnt == 16'd0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt == 16'd0) state_next = ACK;
            ACK:     if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            op_q     <= 2'b00;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                op_q   <= ram_ctrl[1:0];
                addr_q <= addr;
                data_q <= data_in;
                cnt    <= wait_load;
            end else if (state == WAIT && cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end
            if (enter_ack) begin
                err_q <= (op_q == 2'b11) || !in_range;
                if (op_q == 2'b10) begin
                    data_out <= in_range ? mem[idx] : '0;
                end
            end else if (state == ACK && !req) begin
                err_q <= 1'b0;
            end
        end
    end

    // Commit happens only on the single edge that enters ACK.
    always_ff @(posedge clk) begin
        if (enter_ack && op_q == 2'b01 && in_range) begin
            mem[idx] <= data_q;
        end
    end

    always_comb begin
        ram_stat    = '0;
        ram_stat[0] = (state == ACK);
        ram_stat[1] = err_q;
        ram_stat[2] = (state == WAIT);
    end

endmodule

// File: tb/tb_ram_dev.sv
// tb/tb_ram_dev.sv - randomized self-checking bench for ram_dev against a behavioural memory model
module tb_ram_dev;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl [2];
    logic [31:0] ad   [2];
    logic [31:0] din  [2];
    logic [31:0] stat [2];
    logic [31:0] dout [2];

    int checks;
    int failures;

    logic [31:0] mm     [2][1024];
    logic [31:0] dout_m [2];

    // Instance 0 has no wait states, instance 1 has two.
    ram_dev #(.word_width(32), .addr_width(10), .wait_cycles(0)) dut0 (
        .clk(clk), .rst(rst), .ram_ctrl(ctrl[0]), .addr(ad[0]),
        .data_in(din[0]), .ram_stat(stat[0]), .data_out(dout[0])
    );

    ram_dev #(.word_width(32), .addr_width(10), .wait_cycles(2)) dut1 (
        .clk(clk), .rst(rst), .ram_ctrl(ctrl[1]), .addr(ad[1]),
        .data_in(din[1]), .ram_stat(stat[1]), .data_out(dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic txn(input int d, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input bit mid);
        int n;
        int busy_n;
        logic exp_err;
        @(negedge clk);
        ctrl[d] = {30'b0, op};
        ad[d]   = a;
        din[d]  = wd;
        @(posedge clk); #1;
        if (mid) begin
            ad[d]  = $urandom;
            din[d] = $urandom;
        end
        n = 0;
        busy_n = 0;
        while (stat[d][0] !== 1'b1 && n < 20) begin
            if (stat[d][2] === 1'b1) busy_n++;
            @(posedge clk); #1;
            n++;
        end
        chk("ack_latency", n, wc(d) + 1);
        chk("busy_cycles", busy_n, wc(d) + 1);
        exp_err = (op == 2'b11) || (a >= 32'd1024);
        if (!exp_err && op == 2'b01) mm[d][a[9:0]] = wd;
        if (op == 2'b10) dout_m[d] = exp_err ? 32'd0 : mm[d][a[9:0]];
        chk("ack_stat", stat[d], {29'b0, 1'b0, exp_err, 1'b1});
        chk("ack_dout", dout[d], dout_m[d]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("ack_held", stat[d], {29'b0, 1'b0, exp_err, 1'b1});
        end
        ctrl[d] = 32'd0;
        @(posedge clk); #1;
        chk("idle_stat", stat[d], 32'd0);
        chk("idle_dout", dout[d], dout_m[d]);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        int          d;
        int          r;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 2; k++) begin
            ctrl[k] = 32'd0; ad[k] = 32'd0; din[k] = 32'd0; dout_m[k] = 32'd0;
            for (int j = 0; j < 1024; j++) mm[k][j] = 32'd0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_stat", stat[k], 32'd0);
            chk("reset_dout", dout[k], 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 64; j++) txn(k, 2'b01, j, 32'd0, 0, 1'b0);

        txn(1, 2'b01, 32'd5, 32'hDEADBEEF, 0, 1'b0);
        txn(1, 2'b10, 32'd5, 32'd0, 0, 1'b0);
        txn(0, 2'b01, 32'd0, 32'h12, 0, 1'b0);
        txn(0, 2'b10, 32'd0, 32'd0, 0, 1'b0);
        txn(1, 2'b01, 32'd1024, 32'd7, 0, 1'b0);
        txn(1, 2'b10, 32'd0, 32'd0, 0, 1'b0);
        txn(1, 2'b10, 32'h8000_0000, 32'd0, 0, 1'b0);
        txn(1, 2'b10, 32'd5, 32'd0, 0, 1'b0);
        txn(1, 2'b11, 32'd9, 32'h55, 1, 1'b0);
        txn(1, 2'b10, 32'd9, 32'd0, 0, 1'b0);
        txn(1, 2'b01, 32'd17, 32'hCAFE_0017, 10, 1'b1);
        txn(1, 2'b10, 32'd17, 32'd0, 0, 1'b0);
        txn(0, 2'b01, 32'd18, 32'h0BAD_0018, 10, 1'b1);
        txn(0, 2'b10, 32'd18, 32'd0, 0, 1'b0);

        // Abort a write in its wait phase; the array must keep the old value.
        @(negedge clk);
        ctrl[1] = 32'd1; ad[1] = 32'd3; din[1] = 32'hAA;
        @(posedge clk); #1;
        chk("abort_busy", stat[1], 32'd4);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_stat", stat[k], 32'd0);
            chk("abort_dout", dout[k], 32'd0);
            dout_m[k] = 32'd0;
        end
        ctrl[1] = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        txn(1, 2'b10, 32'd3, 32'd0, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            op = (r < 45) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 99);
            if (r < 85)      a = $urandom_range(0, 63);
            else if (r < 93) a = 32'd1024 + $urandom_range(0, 5000);
            else             a = $urandom | 32'h8000_0000;
            txn(d, op, a, $urandom, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
